// File: rtl/randsack_pkg.sv
// Shared encodings and constants for the randsack register-file arbiter.
package randsack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    localparam logic [31:0] RANDSACK_ERR_DATA = 32'hDEAD_BEEF;

    localparam int RANDSACK_AW      = 8;
    localparam int RANDSACK_DW      = 32;
    localparam int RANDSACK_NREQ    = 3;
    localparam int RANDSACK_TIMEOUT = 64;

endpackage

// File: rtl/randsack_rr_picker.sv
// Combinational round-robin select: first set request after last_i, wrapping modulo N.
module randsack_rr_picker
    import randsack_pkg::*;
#(
    parameter int N  = RANDSACK_NREQ,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    int cand;

    // Walk offsets from farthest to nearest so the nearest hit after last_i wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int off = N; off >= 1; off--) begin
            cand = (int'(last_i) + off) % N;
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/randsack_reg_arbiter.sv
// Round-robin arbiter sharing one randsack register-file port, one transaction at a time, with timeout.
module randsack_reg_arbiter
    import randsack_pkg::*;
#(
    parameter int NREQ    = RANDSACK_NREQ,
    parameter int AW      = RANDSACK_AW,
    parameter int DW      = RANDSACK_DW,
    parameter int TIMEOUT = RANDSACK_TIMEOUT
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ-1:0]          we_i,
    input  logic [NREQ*AW-1:0]       addr_i,
    input  logic [NREQ*DW-1:0]       wdata_i,
    output logic [NREQ-1:0]          ack_o,
    output logic [NREQ-1:0]          err_o,
    output logic [DW-1:0]            rdata_o,
    output logic                     reg_cyc_o,
    output logic                     reg_we_o,
    output logic [AW-1:0]            reg_addr_o,
    output logic [DW-1:0]            reg_wdata_o,
    input  logic                     reg_ack_i,
    input  logic [DW-1:0]            reg_rdata_i,
    output logic                     busy_o,
    output logic [$clog2(NREQ)-1:0]  grant_o
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT) + 1;

    state_e            state_q,     state_d;
    logic [GW-1:0]     last_q,      last_d;
    logic [GW-1:0]     grant_q,     grant_d;
    logic [CW-1:0]     cnt_q,       cnt_d;
    logic              reg_cyc_q,   reg_cyc_d;
    logic              reg_we_q,    reg_we_d;
    logic [AW-1:0]     reg_addr_q,  reg_addr_d;
    logic [DW-1:0]     reg_wdata_q, reg_wdata_d;
    logic [DW-1:0]     rdata_q,     rdata_d;
    logic [NREQ-1:0]   ack_q,       ack_d;
    logic [NREQ-1:0]   err_q,       err_d;

    logic              pick_valid;
    logic [GW-1:0]     pick_idx;

    randsack_rr_picker #(
        .N  (NREQ),
        .IW (GW)
    ) u_picker (
        .req_i   (req_i),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        reg_cyc_d   = reg_cyc_q;
        reg_we_d    = reg_we_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        rdata_d     = rdata_q;
        ack_d       = '0;
        err_d       = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d     = pick_idx;
                    last_d      = pick_idx;
                    reg_we_d    = we_i[pick_idx];
                    reg_addr_d  = addr_i[int'(pick_idx)*AW +: AW];
                    reg_wdata_d = wdata_i[int'(pick_idx)*DW +: DW];
                    reg_cyc_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                // A completing ack takes priority over a simultaneous timeout.
                if (reg_ack_i) begin
                    rdata_d        = reg_rdata_i;
                    reg_cyc_d      = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    state_d        = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d        = DW'(RANDSACK_ERR_DATA);
                    reg_cyc_d      = 1'b0;
                    err_d[grant_q] = 1'b1;
                    state_d        = ST_RESP;
                end
            end
            ST_RESP: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                reg_cyc_d = 1'b0;
                cnt_d     = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            last_q      <= GW'(NREQ - 1);
            grant_q     <= '0;
            cnt_q       <= '0;
            reg_cyc_q   <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            rdata_q     <= '0;
            ack_q       <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            reg_cyc_q   <= reg_cyc_d;
            reg_we_q    <= reg_we_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign reg_cyc_o   = reg_cyc_q;
    assign reg_we_o    = reg_we_q;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign grant_o     = grant_q;

endmodule

// File: tb/tb_randsack_reg_arbiter.sv
// Directed bench for randsack_reg_arbiter: requester drivers, downstream responder, scoreboard monitor.
module tb_randsack_reg_arbiter;

    localparam int NREQ    = 3;
    localparam int AW      = 8;
    localparam int DW      = 32;
    localparam int TIMEOUT = 64;
    localparam int GW      = 2;
    localparam int EW      = 8 + 1 + GW + DW;
    localparam int IW      = 1 + AW + DW;
    localparam int RW      = 8 + DW;

    logic                  wb_clk_i;
    logic                  wb_rst_i;
    logic [NREQ-1:0]       req_i;
    logic [NREQ-1:0]       we_i;
    logic [NREQ*AW-1:0]    addr_i;
    logic [NREQ*DW-1:0]    wdata_i;
    logic [NREQ-1:0]       ack_o;
    logic [NREQ-1:0]       err_o;
    logic [DW-1:0]         rdata_o;
    logic                  reg_cyc_o;
    logic                  reg_we_o;
    logic [AW-1:0]         reg_addr_o;
    logic [DW-1:0]         reg_wdata_o;
    logic                  reg_ack_i;
    logic [DW-1:0]         reg_rdata_i;
    logic                  busy_o;
    logic [GW-1:0]         grant_o;

    logic [EW-1:0] exp_q[$];
    logic [IW-1:0] iss_q[$];
    logic [RW-1:0] rsp_q[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle    = 0;
    logic inject_ack;

    randsack_reg_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .ack_o       (ack_o),
        .err_o       (err_o),
        .rdata_o     (rdata_o),
        .reg_cyc_o   (reg_cyc_o),
        .reg_we_o    (reg_we_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_ack_i   (reg_ack_i),
        .reg_rdata_i (reg_rdata_i),
        .busy_o      (busy_o),
        .grant_o     (grant_o)
    );

    // Clock and cycle count
    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;
    always @(posedge wb_clk_i) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [EW-1:0] mk_exp(input int lat, input logic err, input int idx,
                                             input logic [DW-1:0] data);
        return {8'(lat), err, GW'(idx), data};
    endfunction

    function automatic logic [IW-1:0] mk_iss(input logic we, input logic [AW-1:0] a,
                                             input logic [DW-1:0] wd);
        return {we, a, wd};
    endfunction

    function automatic logic [RW-1:0] mk_rsp(input int delay, input logic [DW-1:0] data);
        return {8'(delay), data};
    endfunction

    // Driver tasks
    task automatic do_reset();
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
    endtask

    task automatic do_txn(input int k, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd);
        int n;
        @(posedge wb_clk_i); #1;
        req_i[k]             = 1'b1;
        we_i[k]              = we;
        addr_i[k*AW +: AW]   = a;
        wdata_i[k*DW +: DW]  = wd;
        n = 0;
        while (!(ack_o[k] || err_o[k]) && n < 200) begin
            @(posedge wb_clk_i); #1;
            n++;
        end
        if (n >= 200) check("txn_wait_expired", 64'(n), 64'(0));
        @(posedge wb_clk_i); #1;
        req_i[k] = 1'b0;
    endtask

    // Downstream register file model: ack after a per-transaction delay (0 = never)
    initial begin : responder
        logic          active;
        int            cnt;
        logic [RW-1:0] r;
        active      = 1'b0;
        cnt         = 0;
        r           = '0;
        reg_ack_i   = 1'b0;
        reg_rdata_i = '0;
        forever begin
            @(posedge wb_clk_i); #1;
            reg_ack_i   = 1'b0;
            reg_rdata_i = '0;
            if (!reg_cyc_o) begin
                active = 1'b0;
            end else if (!active) begin
                active = 1'b1;
                cnt    = 1;
                r      = (rsp_q.size() > 0) ? rsp_q.pop_front() : '0;
            end else begin
                cnt++;
            end
            if (active && r[RW-1:DW] != 8'd0 && cnt == int'(r[RW-1:DW])) begin
                reg_ack_i   = 1'b1;
                reg_rdata_i = r[DW-1:0];
            end
            if (inject_ack) begin
                reg_ack_i   = 1'b1;
                reg_rdata_i = 32'h0BAD_0BAD;
            end
        end
    end

    // Scoreboard monitor: checks each downstream issue and each response pulse
    initial begin : monitor
        logic [EW-1:0]   e;
        logic [IW-1:0]   it;
        logic [NREQ-1:0] oh;
        logic            cyc_prev;
        int              t0;
        cyc_prev = 1'b0;
        t0       = 0;
        forever begin
            @(negedge wb_clk_i);
            if (reg_cyc_o && !cyc_prev) begin
                t0 = cycle;
                if (iss_q.size() == 0) begin
                    check("unexpected_issue", 64'(reg_addr_o), 64'hFFFF);
                end else begin
                    it = iss_q.pop_front();
                    check("issue_we",    64'(reg_we_o),    64'(it[IW-1]));
                    check("issue_addr",  64'(reg_addr_o),  64'(it[DW +: AW]));
                    check("issue_wdata", 64'(reg_wdata_o), 64'(it[DW-1:0]));
                end
            end
            cyc_prev = reg_cyc_o;
            if ((|ack_o) || (|err_o)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 64'({ack_o, err_o}), 64'(0));
                end else begin
                    e  = exp_q.pop_front();
                    oh = '0;
                    oh[e[DW +: GW]] = 1'b1;
                    check("resp_latency", 64'(cycle - t0), 64'(e[EW-1 -: 8]));
                    check("resp_ack",     64'(ack_o), e[DW+GW] ? 64'(0) : 64'(oh));
                    check("resp_err",     64'(err_o), e[DW+GW] ? 64'(oh) : 64'(0));
                    check("resp_grant",   64'(grant_o), 64'(e[DW +: GW]));
                    check("resp_rdata",   64'(rdata_o), 64'(e[DW-1:0]));
                    check("resp_busy",    64'(busy_o), 64'(1));
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : main
        int n;
        wb_rst_i   = 1'b1;
        req_i      = '0;
        we_i       = '0;
        addr_i     = '0;
        wdata_i    = '0;
        inject_ack = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;

        @(negedge wb_clk_i);
        check("reset_busy",    64'(busy_o),      64'(0));
        check("reset_grant",   64'(grant_o),     64'(0));
        check("reset_cyc",     64'(reg_cyc_o),   64'(0));
        check("reset_ack",     64'(ack_o),       64'(0));
        check("reset_err",     64'(err_o),       64'(0));
        check("reset_rdata",   64'(rdata_o),     64'(0));
        check("reset_addr",    64'(reg_addr_o),  64'(0));
        check("reset_wdata",   64'(reg_wdata_o), 64'(0));

        // Single write from requester 0
        iss_q.push_back(mk_iss(1'b1, 8'h04, 32'h5555_5555));
        rsp_q.push_back(mk_rsp(1, 32'h0000_0000));
        exp_q.push_back(mk_exp(1, 1'b0, 0, 32'h0000_0000));
        do_txn(0, 1'b1, 8'h04, 32'h5555_5555);
        @(negedge wb_clk_i);
        check("single_write_busy_after", 64'(busy_o), 64'(0));

        // Simultaneous reads from 0 and 1 straight after reset
        do_reset();
        iss_q.push_back(mk_iss(1'b0, 8'h10, 32'h0));
        iss_q.push_back(mk_iss(1'b0, 8'h14, 32'h0));
        rsp_q.push_back(mk_rsp(1, 32'hAAAA_AAAA));
        rsp_q.push_back(mk_rsp(1, 32'h0000_FEED));
        exp_q.push_back(mk_exp(1, 1'b0, 0, 32'hAAAA_AAAA));
        exp_q.push_back(mk_exp(1, 1'b0, 1, 32'h0000_FEED));
        fork
            do_txn(0, 1'b0, 8'h10, 32'h0);
            do_txn(1, 1'b0, 8'h14, 32'h0);
        join

        // Fairness: all three keep requesting, expected grant order 0,1,2,0,1,2
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NREQ; k++) begin
                iss_q.push_back(mk_iss(1'b0, 8'(8'h40 + 8'(r*4 + k)), 32'h0));
                rsp_q.push_back(mk_rsp(1, 32'h1000 + 32'(r*16 + k)));
                exp_q.push_back(mk_exp(1, 1'b0, k, 32'h1000 + 32'(r*16 + k)));
            end
        end
        fork
            begin
                do_txn(0, 1'b0, 8'h40, 32'h0);
                do_txn(0, 1'b0, 8'h44, 32'h0);
            end
            begin
                do_txn(1, 1'b0, 8'h41, 32'h0);
                do_txn(1, 1'b0, 8'h45, 32'h0);
            end
            begin
                do_txn(2, 1'b0, 8'h42, 32'h0);
                do_txn(2, 1'b0, 8'h46, 32'h0);
            end
        join

        // Timeout: no ack ever, requester 1
        do_reset();
        iss_q.push_back(mk_iss(1'b0, 8'h20, 32'h0));
        rsp_q.push_back(mk_rsp(0, 32'h0));
        exp_q.push_back(mk_exp(64, 1'b1, 1, 32'hDEAD_BEEF));
        do_txn(1, 1'b0, 8'h20, 32'h0);

        // Ack on the last ISSUE cycle beats the timeout, requester 2
        iss_q.push_back(mk_iss(1'b0, 8'h24, 32'h0));
        rsp_q.push_back(mk_rsp(64, 32'h0000_1234));
        exp_q.push_back(mk_exp(64, 1'b0, 2, 32'h0000_1234));
        do_txn(2, 1'b0, 8'h24, 32'h0);

        // Reset during the 5th ISSUE cycle of a write from requester 1
        do_reset();
        iss_q.push_back(mk_iss(1'b1, 8'h30, 32'hCAFE_0001));
        rsp_q.push_back(mk_rsp(10, 32'h0));
        @(posedge wb_clk_i); #1;
        req_i[1]         = 1'b1;
        we_i[1]          = 1'b1;
        addr_i[AW +: AW] = 8'h30;
        wdata_i[DW +: DW] = 32'hCAFE_0001;
        n = 0;
        while (!reg_cyc_o && n < 20) begin
            @(posedge wb_clk_i); #1;
            n++;
        end
        check("abort_issue_started", 64'(reg_cyc_o), 64'(1));
        repeat (4) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        req_i[1] = 1'b0;
        @(negedge wb_clk_i);
        check("abort_cyc",   64'(reg_cyc_o), 64'(0));
        check("abort_busy",  64'(busy_o),    64'(0));
        check("abort_ack",   64'(ack_o),     64'(0));
        check("abort_err",   64'(err_o),     64'(0));
        check("abort_grant", 64'(grant_o),   64'(0));
        check("abort_rdata", 64'(rdata_o),   64'(0));
        inject_ack = 1'b1;
        @(negedge wb_clk_i);
        inject_ack = 1'b0;
        check("stray_ack_busy", 64'(busy_o), 64'(0));
        @(negedge wb_clk_i);
        check("stray_ack_no_resp", 64'({ack_o, err_o}), 64'(0));
        check("stray_ack_rdata",   64'(rdata_o),        64'(0));

        // Requesters 2 and 0 together after reset: 0 goes first
        iss_q.push_back(mk_iss(1'b0, 8'h34, 32'h0));
        iss_q.push_back(mk_iss(1'b0, 8'h38, 32'h0));
        rsp_q.push_back(mk_rsp(1, 32'h0000_00A0));
        rsp_q.push_back(mk_rsp(1, 32'h0000_00A2));
        exp_q.push_back(mk_exp(1, 1'b0, 0, 32'h0000_00A0));
        exp_q.push_back(mk_exp(1, 1'b0, 2, 32'h0000_00A2));
        fork
            do_txn(2, 1'b0, 8'h38, 32'h0);
            do_txn(0, 1'b0, 8'h34, 32'h0);
        join

        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(negedge wb_clk_i);
            n++;
        end
        repeat (3) @(negedge wb_clk_i);
        check("exp_q_drained", 64'(exp_q.size()), 64'(0));
        check("iss_q_drained", 64'(iss_q.size()), 64'(0));
        check("final_busy",    64'(busy_o),       64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
